multicycle_main_fsm: RTL and testbench

- Main control state machine of the multicycle ARM datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit select lines of the datapath 4:1 multiplexers (ALUSrcB, ResultSrc) plus all enables.
- Sits directly upstream of the datapath muxes. Its enables are gated by the separate condition-check block before reaching the register file, memory and PC.

---
 rtl/mc_ctrl_pkg.sv | 29 ++
 rtl/mc_ctrl_outdec.sv | 72 +++++++
 rtl/multicycle_main_fsm.sv | 69 ++++++
 tb/tb_multicycle_main_fsm.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, opcode and mux-select encodings for the multicycle controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational decode of controller state into datapath selects and enables
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [1:0] op,
    output logic       ir_write,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic       next_pc,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic       illegal_op
);

    // Moore decode; unused and illegal codes leave every output low
    always_comb begin
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_WD;
        result_src = RES_ALUOUT;
        alu_op     = 1'b0;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                illegal_op = (op == 2'b11);
            end
            S_MEMADR:   alu_src_b = SRCB_IMM;
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = 1'b1;
            end
            S_ALUWB:    reg_w = 1'b1;
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURES;
                branch     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: state register and next-state logic sequencing each ARM instruction
module multicycle_main_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    output logic               ir_write,
    output logic               adr_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic               alu_op,
    output logic               next_pc,
    output logic               reg_w,
    output logic               mem_w,
    output logic               branch,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t state_q, state_d;
    logic   unused_funct;

    assign unused_funct = ^funct[4:1];
    assign state        = STATE_W'(state_q);

    // State register; reset returns to FETCH even mid-instruction
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next state; op/funct only matter in DECODE and MEMADR, unknown codes recover to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = (op == OP_DP)  ? (funct[5] ? S_EXECUTEI : S_EXECUTER) :
                                  (op == OP_MEM) ? S_MEMADR :
                                  (op == OP_BR)  ? S_BRANCH : S_FETCH;
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state      (state_q),
        .op         (op),
        .ir_write   (ir_write),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .next_pc    (next_pc),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .branch     (branch),
        .illegal_op (illegal_op)
    );

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: directed instruction sequences checked against a scoreboard of expected states/outputs
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic       ir_write, adr_src, alu_src_a, alu_op, next_pc, reg_w, mem_w, branch, illegal_op;
    logic [1:0] alu_src_b, result_src;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    logic [16:0] sb [$];

    multicycle_main_fsm #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .ir_write   (ir_write),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .next_pc    (next_pc),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .branch     (branch),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Output vector {ir_write,adr_src,alu_src_a,alu_src_b,result_src,alu_op,next_pc,reg_w,mem_w,branch,illegal_op}
    function automatic logic [12:0] exp_outs(input logic [3:0] s, input logic [1:0] o);
        logic ir, adr, sa, aop, npc, rw, mw, br, ill;
        logic [1:0] sb_sel, rs;
        {ir, adr, sa, aop, npc, rw, mw, br, ill} = '0;
        sb_sel = 2'b00;
        rs = 2'b00;
        case (s)
            4'd0: begin ir = 1; npc = 1; sa = 1; sb_sel = 2'b10; rs = 2'b10; end
            4'd1: begin sa = 1; sb_sel = 2'b10; rs = 2'b10; ill = (o == 2'b11); end
            4'd2: sb_sel = 2'b01;
            4'd3: adr = 1;
            4'd4: begin rs = 2'b01; rw = 1; end
            4'd5: begin adr = 1; mw = 1; end
            4'd6: aop = 1;
            4'd7: begin sb_sel = 2'b01; aop = 1; end
            4'd8: rw = 1;
            4'd9: begin sb_sel = 2'b01; rs = 2'b10; br = 1; end
            default: ;
        endcase
        return {ir, adr, sa, sb_sel, rs, aop, npc, rw, mw, br, ill};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] s, input logic [1:0] o);
        sb.push_back({s, exp_outs(s, o)});
    endtask

    task automatic check_head(input string tag);
        logic [16:0] e;
        logic [12:0] obs;
        e = sb.pop_front();
        obs = {ir_write, adr_src, alu_src_a, alu_src_b, result_src, alu_op, next_pc, reg_w, mem_w, branch, illegal_op};
        checks++;
        assert (state === e[16:13]) else begin
            failures++;
            $error("FAIL %s_state observed=%0d expected=%0d", tag, state, e[16:13]);
        end
        checks++;
        assert (obs === e[12:0]) else begin
            failures++;
            $error("FAIL %s_outs state=%0d observed=%b expected=%b", tag, e[16:13], obs, e[12:0]);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [5:0] f, input int n, input logic [23:0] seq);
        op = o;
        funct = f;
        for (int i = 0; i < n; i++) push(seq[i*4 +: 4], o);
        while (sb.size() > 0) begin
            check_head(tag);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        op = 2'b00;
        funct = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        push(4'd0, op);
        check_head("reset");
        reset = 1'b0;
        run("add",  2'b00, 6'b000000, 4, {8'h00, 4'd8, 4'd6, 4'd1, 4'd0});
        run("addi", 2'b00, 6'b101000, 4, {8'h00, 4'd8, 4'd7, 4'd1, 4'd0});
        run("ldr",  2'b01, 6'b011001, 5, {4'h0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0});
        run("str",  2'b01, 6'b011000, 4, {8'h00, 4'd5, 4'd2, 4'd1, 4'd0});
        run("b",    2'b10, 6'b000000, 3, {12'h000, 4'd9, 4'd1, 4'd0});
        run("ill",  2'b11, 6'b111111, 2, {16'h0000, 4'd1, 4'd0});
        op = 2'b01;
        funct = 6'b011001;
        for (int s = 0; s < 4; s++) begin
            push(4'(s), op);
            check_head("midld");
            if (s < 3) step();
        end
        reset = 1'b1;
        step();
        push(4'd0, op);
        check_head("midrst");
        reset = 1'b0;
        run("ldr2", 2'b01, 6'b011001, 5, {4'h0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0});
        push(4'd0, op);
        check_head("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
